// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and default widths for the two-port data RAM arbiter.
package dmem_arbiter_pkg;

    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 32;
    localparam int DEF_RAM_AW = 10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_P0   = 2'b01,
        OWN_P1   = 2'b10
    } owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the data RAM arbiter.
// DMEM_ARB_RR_EN selects round-robin tie-break; otherwise p0 wins ties.
module dmem_arb_pick (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic [1:0] grant
);

    logic [1:0] cand;
    assign cand = req & ~mask;

    always_comb begin
        grant = cand;
        if (cand == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            // last=1 means p1 was served last, so p0 takes the tie
            grant = last ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end
    end

`ifndef DMEM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port data RAM between CPU (p0) and debug/loader (p1).
// Build option DMEM_ARB_RR_EN: round-robin tie-break in IDLE instead of fixed p0 priority.
//
// state     | meaning
// ST_IDLE   | no command on the RAM; arbitrate incoming requests
// ST_ACCESS | latched request driven to the RAM, owner acked; re-arbitrate with owner masked
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RAM_AW = DEF_RAM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_wen,
    input  logic [AW-1:0]     p0_addr,
    input  logic [DW-1:0]     p0_wdata,
    output logic              p0_ack,
    output logic              p0_rvalid,
    output logic [DW-1:0]     p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wen,
    input  logic [AW-1:0]     p1_addr,
    input  logic [DW-1:0]     p1_wdata,
    output logic              p1_ack,
    output logic              p1_rvalid,
    output logic [DW-1:0]     p1_rdata,
    output logic              ram_en,
    output logic              ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata,
    output logic [1:0]        arb_owner
);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                wen_q, wen_d;
    logic [RAM_AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [1:0]          grant;
    logic [1:0]          rd_pend_q;
    logic [DW-1:0]       hold0_q, hold1_q;
    logic                last_p1;

    logic unused_addr;
    assign unused_addr = ^{p0_addr[AW-1:RAM_AW+2], p0_addr[1:0],
                           p1_addr[AW-1:RAM_AW+2], p1_addr[1:0]};

    // owner_q is OWN_NONE whenever IDLE, so it doubles as the ACCESS-state mask
    dmem_arb_pick u_pick (
        .req   ({p1_req, p0_req}),
        .mask  (owner_q),
        .last  (last_p1),
        .grant (grant)
    );

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_p1 <= 1'b1;
        else if (|grant)
            last_p1 <= grant[1];
    end
`else
    assign last_p1 = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (grant[0]) begin
            state_d = ST_ACCESS;
            owner_d = OWN_P0;
            wen_d   = p0_wen;
            addr_d  = p0_addr[RAM_AW+1:2];
            wdata_d = p0_wdata;
        end else if (grant[1]) begin
            state_d = ST_ACCESS;
            owner_d = OWN_P1;
            wen_d   = p1_wen;
            addr_d  = p1_addr[RAM_AW+1:2];
            wdata_d = p1_wdata;
        end else begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_pend_q <= '0;
            hold0_q   <= '0;
            hold1_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_pend_q <= {p1_ack & ~wen_q, p0_ack & ~wen_q};
            if (rd_pend_q[0])
                hold0_q <= ram_rdata;
            if (rd_pend_q[1])
                hold1_q <= ram_rdata;
        end
    end

    assign ram_en    = (state_q == ST_ACCESS);
    assign ram_wen   = ram_en & wen_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign arb_owner = ram_en ? owner_q : OWN_NONE;
    assign p0_ack    = ram_en && (owner_q == OWN_P0);
    assign p1_ack    = ram_en && (owner_q == OWN_P1);
    assign p0_rvalid = rd_pend_q[0];
    assign p1_rvalid = rd_pend_q[1];
    assign p0_rdata  = rd_pend_q[0] ? ram_rdata : hold0_q;
    assign p1_rdata  = rd_pend_q[1] ? ram_rdata : hold1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural single-port RAM.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 0, p0_wen = 0, p1_req = 0, p1_wen = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_ack, p0_rvalid, p1_ack, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        ram_en, ram_wen;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [1:0]  arb_owner;

    int pass_cnt = 0;
    int total = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen) mem[ram_addr] <= ram_wdata;
            else         ram_rdata     <= mem[ram_addr];
        end
    end

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .arb_owner(arb_owner)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [148:0] all_outs();
        return {p0_ack, p0_rvalid, p0_rdata, p1_ack, p1_rvalid, p1_rdata,
                ram_en, ram_wen, ram_addr, ram_wdata, arb_owner};
    endfunction

    task automatic test_reset();
        logic seen;
        step(); step();
        @(negedge clk);
        total++; if (all_outs() !== '0) $display("FAIL reset_outs act=%h exp=0", all_outs()); else pass_cnt++;
        step(); rst = 0;
        step(); p0_req = 1; p0_wen = 0; p0_addr = 32'h40;
        step();
        @(negedge clk);
        total++; if (p0_ack !== 1'b1) $display("FAIL rst_pre_ack act=%b exp=1", p0_ack); else pass_cnt++;
        #1 rst = 1; p0_req = 0;
        #1;
        total++; if (all_outs() !== '0) $display("FAIL rst_midread act=%h exp=0", all_outs()); else pass_cnt++;
        step(); step(); rst = 0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) seen = 1;
            step();
        end
        total++; if (seen !== 1'b0) $display("FAIL rst_no_rvalid act=%b exp=0", seen); else pass_cnt++;
    endtask

    task automatic test_write_read();
        p0_req = 1; p0_wen = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (p0_ack !== 1'b0) $display("FAIL wr_req_cycle_ack act=%b exp=0", p0_ack); else pass_cnt++;
        step();
        @(negedge clk);
        total++; if ({p0_ack, ram_en, ram_wen, ram_addr, ram_wdata, arb_owner} !== {3'b111, 10'd4, 32'hDEADBEEF, 2'b01})
            $display("FAIL wr_ack_cmd act=%b%b%b a=%h d=%h o=%b exp=111 a=004 d=deadbeef o=01",
                     p0_ack, ram_en, ram_wen, ram_addr, ram_wdata, arb_owner);
        else pass_cnt++;
        step(); p0_wen = 0;
        @(negedge clk);
        total++; if ({p0_ack, ram_en} !== 2'b00) $display("FAIL rd_idle_gap act=%b%b exp=00", p0_ack, ram_en); else pass_cnt++;
        step();
        @(negedge clk);
        total++; if ({p0_ack, ram_wen, ram_addr} !== {2'b10, 10'd4})
            $display("FAIL rd_ack act=%b%b a=%h exp=10 a=004", p0_ack, ram_wen, ram_addr);
        else pass_cnt++;
        step(); p0_req = 0;
        @(negedge clk);
        total++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'hDEADBEEF})
            $display("FAIL rd_rvalid act=%b %h exp=1 deadbeef", p0_rvalid, p0_rdata);
        else pass_cnt++;
        step();
        @(negedge clk);
        total++; if ({p0_rvalid, p0_rdata} !== {1'b0, 32'hDEADBEEF})
            $display("FAIL rd_hold act=%b %h exp=0 deadbeef", p0_rvalid, p0_rdata);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        rst = 1; step(); rst = 0;
        step();
        p0_req = 1; p0_wen = 1; p0_addr = 32'h20; p0_wdata = 32'h5555AAAA;
        p1_req = 1; p1_wen = 0; p1_addr = 32'h10;
        step();
        @(negedge clk);
        total++; if ({p0_ack, p1_ack, arb_owner} !== 4'b1001)
            $display("FAIL sim_first act=%b%b o=%b exp=10 o=01", p0_ack, p1_ack, arb_owner);
        else pass_cnt++;
        step(); p0_req = 0;
        @(negedge clk);
        total++; if ({p0_ack, p1_ack, arb_owner, ram_wen, ram_addr} !== {4'b0110, 1'b0, 10'd4})
            $display("FAIL sim_second act=%b%b o=%b w=%b a=%h exp=01 o=10 w=0 a=004",
                     p0_ack, p1_ack, arb_owner, ram_wen, ram_addr);
        else pass_cnt++;
        step(); p1_req = 0;
        @(negedge clk);
        total++; if ({p1_rvalid, p0_rvalid, p1_rdata} !== {2'b10, 32'hDEADBEEF})
            $display("FAIL sim_p1_rdata act=%b%b %h exp=10 deadbeef", p1_rvalid, p0_rvalid, p1_rdata);
        else pass_cnt++;
        step();
        @(negedge clk);
        total++; if ({ram_en, arb_owner} !== 3'b000) $display("FAIL sim_idle act=%b o=%b exp=0 o=00", ram_en, arb_owner); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        p0_req = 1; p0_wen = 0; p0_addr = 32'h10;
        p1_req = 1; p1_wen = 1; p1_addr = 32'h30; p1_wdata = 32'h77;
        step();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp = (i % 2 == 0) ? 4'b1000 : 4'b0110;
            total++; if ({p0_ack, p1_ack, p0_rvalid, p1_rvalid} !== exp)
                $display("FAIL b2b_%0d ack0,ack1,rv0,rv1 act=%b exp=%b", i, {p0_ack, p1_ack, p0_rvalid, p1_rvalid}, exp);
            else pass_cnt++;
            step();
            if (i == 4) p0_req = 0;
            if (i == 5) p1_req = 0;
        end
        @(negedge clk);
        total++; if ({ram_en, p0_rvalid, p1_rvalid, p0_rdata} !== {3'b000, 32'hDEADBEEF})
            $display("FAIL b2b_end act=%b%b%b %h exp=000 deadbeef", ram_en, p0_rvalid, p1_rvalid, p0_rdata);
        else pass_cnt++;
    endtask

    task automatic test_rr_tie();
        logic [1:0] exp_first;
`ifdef DMEM_ARB_RR_EN
        exp_first = 2'b10;
`else
        exp_first = 2'b01;
`endif
        step();
        p0_req = 1; p0_wen = 1; p0_addr = 32'h50; p0_wdata = 32'h1;
        step();
        @(negedge clk);
        total++; if (p0_ack !== 1'b1) $display("FAIL tie_solo act=%b exp=1", p0_ack); else pass_cnt++;
        step();
        p0_addr = 32'h54; p0_wdata = 32'h2;
        p1_req = 1; p1_wen = 1; p1_addr = 32'h58; p1_wdata = 32'h3;
        step();
        @(negedge clk);
        total++; if ({p1_ack, p0_ack} !== exp_first || arb_owner !== exp_first)
            $display("FAIL tie_winner act=%b o=%b exp=%b", {p1_ack, p0_ack}, arb_owner, exp_first);
        else pass_cnt++;
        step();
        if (exp_first[0]) p0_req = 0; else p1_req = 0;
        @(negedge clk);
        total++; if ({p1_ack, p0_ack} !== ~exp_first)
            $display("FAIL tie_loser act=%b exp=%b", {p1_ack, p0_ack}, ~exp_first);
        else pass_cnt++;
        step(); p0_req = 0; p1_req = 0;
        step();
    endtask

    task automatic test_wr_rd_same();
        p1_req = 1; p1_wen = 1; p1_addr = 32'h3FC; p1_wdata = 32'h1234;
        step();
        p0_req = 1; p0_wen = 0; p0_addr = 32'h3FC;
        @(negedge clk);
        total++; if ({p1_ack, ram_wen, ram_addr} !== {2'b11, 10'h0FF})
            $display("FAIL same_wr act=%b%b a=%h exp=11 a=0ff", p1_ack, ram_wen, ram_addr);
        else pass_cnt++;
        step(); p1_req = 0;
        @(negedge clk);
        total++; if ({p0_ack, ram_wen, ram_addr} !== {2'b10, 10'h0FF})
            $display("FAIL same_rd act=%b%b a=%h exp=10 a=0ff", p0_ack, ram_wen, ram_addr);
        else pass_cnt++;
        step(); p0_req = 0;
        @(negedge clk);
        total++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'h1234})
            $display("FAIL same_p0_rdata act=%b %h exp=1 00001234", p0_rvalid, p0_rdata);
        else pass_cnt++;
        total++; if ({p1_rvalid, p1_rdata} !== {1'b0, 32'hDEADBEEF})
            $display("FAIL same_p1_hold act=%b %h exp=0 deadbeef", p1_rvalid, p1_rdata);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_rr_tie();
        test_wr_rd_same();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
